// File: rtl/add_seq_32bit.sv
// Two-cycle 32-bit adder that reuses one 16-bit carry-lookahead adder.
// The low half is added first and its carry is registered for the high half.
module carry_look_ahead_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate per nibble, carries looked ahead across groups.
  always_comb begin
    gc = '0;
    gg = '0;
    gp = '0;
    c  = '0;
    gc[0] = cin;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    for (int j = 0; j < 4; j++) begin
      c[4*j] = gc[j];
      for (int i = 0; i < 3; i++) begin
        c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
      end
    end
    c[16] = gc[4];
  end

  assign sum  = p ^ c[15:0];
  assign cout = c[16];

endmodule

module add_seq_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        cout,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        cin_r;
  logic        carry_r;
  logic [31:0] sum_r;
  logic        cout_r;
  logic        ovf_r;
  logic        in_ready_r;
  logic        out_valid_r;

  logic [15:0] cla_a;
  logic [15:0] cla_b;
  logic        cla_cin;
  logic [15:0] cla_sum;
  logic        cla_cout;

  // Adder inputs stay at zero outside LO/HI so it does not toggle idly.
  always_comb begin
    cla_a   = '0;
    cla_b   = '0;
    cla_cin = 1'b0;
    unique case (state)
      LO: begin
        cla_a   = a_r[15:0];
        cla_b   = b_r[15:0];
        cla_cin = cin_r;
      end
      HI: begin
        cla_a   = a_r[31:16];
        cla_b   = b_r[31:16];
        cla_cin = carry_r;
      end
      default: ;
    endcase
  end

  carry_look_ahead_16bit u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (cla_cin),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      cin_r       <= 1'b0;
      carry_r     <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            cin_r      <= cin;
            in_ready_r <= 1'b0;
            state      <= LO;
          end
        end
        LO: begin
          sum_r[15:0] <= cla_sum;
          carry_r     <= cla_cout;
          state       <= HI;
        end
        HI: begin
          sum_r[31:16] <= cla_sum;
          cout_r       <= cla_cout;
          ovf_r        <= (a_r[31] == b_r[31]) & (cla_sum[15] != a_r[31]);
          out_valid_r  <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign overflow  = ovf_r;

endmodule
